decode_issue_stage: RTL
=======================

Name: decode_issue_stage

Overview:
- Pipelined successor to the combinational decode step: registered decode/operand-read stage between fetch and execute.
- Valid/ready handshakes on both sides, widths and register count parametrised.
- Per-register pending-write scoreboard stalls RAW hazards; flush input from branch resolution.
- Register file is external: this block drives read addresses and samples the combinational read data.

Parameters:
- BUS, 32, datapath width (operands, PC, immediates zero-extended to BUS).
- NUM_REGS, 16, architectural registers; index NUM_REGS-1 is the "no register" index and is never tracked or stalled on.
- RA_W, 4, register address width, must equal clog2(NUM_REGS).
- PEND_W, 2, width of each scoreboard pending-write counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active low.
- in_valid  in  1  fetch presents instruction.
- in_ready  out  1  stage accepts instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  BUS  instruction PC.
- rf_ra_addr, rf_rb_addr  out  RA_W  register file read addresses (combinational from in_instr).
- rf_ra_data, rf_rb_data  in  BUS  register file read data.
- wb_we  in  1  writeback strobe.
- wb_rd  in  RA_W  writeback destination.
- wb_data  in  BUS  writeback data.
- flush  in  1  kill held and incoming instruction.
- out_valid  out  1  decoded bundle valid.
- out_ready  in  1  execute accepts bundle.
- out_funtype, out_funcode  out  2  instr[31:30], instr[29:28].
- out_rd  out  RA_W  destination, instr[27:24].
- out_opa, out_opb  out  BUS  operands.
- out_pc  out  BUS  registered in_pc.
- out_wb, out_memrd, out_memwr, out_branch  out  1  control flags.
- busy_mask  out  NUM_REGS  bit i set when counter i is non-zero.

Behaviour:
- Reset: all outputs 0, all counters 0. in_ready is 0 while rst_n is low.
- Decode fields:
  - RD=[27:24], RS=[23:20], RX=[19:16], selimm=[0].
  - Imm19=[19:1], Imm28=[27:0], Imm4=[23:20], all zero-extended.
- Control flags:
  - wb = (type 00 and code!=11) | (01/00) | type 10 | (11/00).
  - memrd = 01/00; memwr = 01/01; branch = type 10; cachewr = 11/10.
- Operand A source:
  - A = RS when wb or memrd or memwr; otherwise A = RD (CMP case).
  - Zero case: MOV (00/10) or type 11 → out_opa=0 and no A source.
- Operand B:
  - selimm or cachewr → out_opb = immediate: Imm4 if cachewr, else Imm19 if type 00, else Imm28; no B source.
  - Otherwise out_opb = rf_rb_data from RX.
- Hazard stall. Stall asserts when in_valid, a used source S != NUM_REGS-1, and either:
  - counter[S] != 0, or
  - out_valid & out_wb & out_rd==S.
- A writer whose counter[RD] is all-ones also stalls.
- Handshake:
  - in_ready = flush | (~stall & (~out_valid | out_ready)).
  - in fire → bundle registered; out_valid=1 on the next edge (latency 1).
  - The bundle holds stable while out_valid & ~out_ready.
- Scoreboard:
  - On out fire with out_wb and out_rd != NUM_REGS-1, counter[out_rd] +1.
  - On wb_we, counter[wb_rd] -1.
  - Increment and decrement of the same register in one cycle → unchanged.
  - Decrement of a zero counter is ignored (no underflow).
- Flush:
  - Next edge: out_valid=0. The instruction presented that cycle is consumed and discarded.
  - Flush takes priority over capture and over out fire; the scoreboard is not incremented.
  - Counters are not cleared, since already-issued writers still write back.
- Async reset mid-operation clears the bundle and counters immediately.

Optional Feature:
- Macro: DECODE_WB_BYPASS_EN.
- Defined:
  - A source S with wb_we & wb_rd==S in the same cycle takes wb_data instead of rf data.
  - Its hazard term counts counter[S] as (counter[S]-1).
  - A single pending write retiring therefore does not stall.
- Undefined: no bypass; stall until the cycle after counter reaches 0.

Test Plan:
- Reset, then ADD R1,R2,R3 (type 00/00, selimm=0) with R2=5, R3=7, out_ready=1 → next cycle out_valid=1, opa=5, opb=7, out_wb=1; after fire busy_mask[1]=1.
- ADD R1 issued, then SUB R4,R1,R2 → in_ready=0 until wb_we wb_rd=1. Bypass build: accepted that same cycle with opa=wb_data. Non-bypass build: accepted next cycle.
- MOV R5,#0x1234 (00/10, selimm=1) → opa=0, opb=0x91A (Imm19), no stall even if R5 busy.
- out_ready=0 for 3 cycles with a held bundle → bundle stable, in_ready=0. Then flush → out_valid=0 next cycle, busy_mask unchanged.
- Issue 3 writers to R6 with no writeback → 4th writer to R6 stalls (PEND_W=2 saturates at 3). Simultaneous wb R6 and issue R6 → count stays 3.
- Assert rst_n=0 while out_valid=1 and busy_mask≠0 → out_valid=0, busy_mask=0 immediately without a clock edge.

Source files
------------

// File: rtl/decode_issue_stage_if.sv
// Handshake and bus bundle for decode_issue_stage.
// slave  : the decode/issue stage itself.
// master : the surrounding pipeline (fetch, register file, writeback, execute).
interface decode_issue_stage_if #(
    parameter int BUS      = 32,
    parameter int NUM_REGS = 16,
    parameter int RA_W     = 4
);
    // Fetch side
    logic                in_valid;
    logic                in_ready;
    logic [31:0]         in_instr;
    logic [BUS-1:0]      in_pc;
    // External register file read ports
    logic [RA_W-1:0]     rf_ra_addr;
    logic [RA_W-1:0]     rf_rb_addr;
    logic [BUS-1:0]      rf_ra_data;
    logic [BUS-1:0]      rf_rb_data;
    // Writeback and branch resolution
    logic                wb_we;
    logic [RA_W-1:0]     wb_rd;
    logic [BUS-1:0]      wb_data;
    logic                flush;
    // Execute side
    logic                out_valid;
    logic                out_ready;
    logic [1:0]          out_funtype;
    logic [1:0]          out_funcode;
    logic [RA_W-1:0]     out_rd;
    logic [BUS-1:0]      out_opa;
    logic [BUS-1:0]      out_opb;
    logic [BUS-1:0]      out_pc;
    logic                out_wb;
    logic                out_memrd;
    logic                out_memwr;
    logic                out_branch;
    // Scoreboard view
    logic [NUM_REGS-1:0] busy_mask;

    modport slave (
        input  in_valid, in_instr, in_pc, rf_ra_data, rf_rb_data,
        input  wb_we, wb_rd, wb_data, flush, out_ready,
        output in_ready, rf_ra_addr, rf_rb_addr,
        output out_valid, out_funtype, out_funcode, out_rd, out_opa, out_opb, out_pc,
        output out_wb, out_memrd, out_memwr, out_branch, busy_mask
    );

    modport master (
        output in_valid, in_instr, in_pc, rf_ra_data, rf_rb_data,
        output wb_we, wb_rd, wb_data, flush, out_ready,
        input  in_ready, rf_ra_addr, rf_rb_addr,
        input  out_valid, out_funtype, out_funcode, out_rd, out_opa, out_opb, out_pc,
        input  out_wb, out_memrd, out_memwr, out_branch, busy_mask
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Registered decode / operand-read stage between fetch and execute.
// A per-register pending-write scoreboard stalls RAW hazards; flush kills the
// held bundle and the instruction presented in the same cycle.
// Optional feature macro: DECODE_WB_BYPASS_EN -- forwards same-cycle writeback
// data into the operands and lets a single retiring write release a stall.
module decode_issue_stage #(
    parameter int BUS      = 32,
    parameter int NUM_REGS = 16,
    parameter int RA_W     = 4,
    parameter int PEND_W   = 2
) (
    input logic                 clk,
    input logic                 rst_n,
    decode_issue_stage_if.slave bus
);
    localparam logic [RA_W-1:0]   NO_REG   = RA_W'(NUM_REGS - 1);
    localparam logic [PEND_W-1:0] CNT_MAX  = '1;
    localparam logic [PEND_W-1:0] CNT_NEAR = PEND_W'((2 ** PEND_W) - 2);

    // Instruction fields
    logic [1:0]      ftype;
    logic [1:0]      fcode;
    logic [RA_W-1:0] f_rd;
    logic [RA_W-1:0] f_rs;
    logic [RA_W-1:0] f_rx;
    logic            selimm;

    assign ftype  = bus.in_instr[31:30];
    assign fcode  = bus.in_instr[29:28];
    assign f_rd   = RA_W'(bus.in_instr[27:24]);
    assign f_rs   = RA_W'(bus.in_instr[23:20]);
    assign f_rx   = RA_W'(bus.in_instr[19:16]);
    assign selimm = bus.in_instr[0];

    // Decoded controls and operand selection
    logic            d_wb, d_memrd, d_memwr, d_branch, d_cachewr;
    logic            a_zero, a_used, b_used;
    logic [RA_W-1:0] a_addr;
    logic [BUS-1:0]  imm_val;

    // Scoreboard state and hazard terms
    logic [PEND_W-1:0]   cnt     [NUM_REGS];
    logic [PEND_W-1:0]   cnt_nxt [NUM_REGS];
    logic [PEND_W-1:0]   cnt_a, cnt_b;
    logic                byp_a, byp_b;
    logic                held_a, held_b, held_rd;
    logic                haz_a, haz_b, rd_full, stall;
    logic                in_fire, out_fire;
    logic [NUM_REGS-1:0] inc_vec, dec_vec, busy;
    logic [BUS-1:0]      opa_val, opb_val;

    // Instruction decode: control flags, operand sources and immediate
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
        d_wb      = (ftype == 2'b00 && fcode != 2'b11) || (ftype == 2'b01 && fcode == 2'b00) ||
                    (ftype == 2'b10) || (ftype == 2'b11 && fcode == 2'b00);
        d_memrd   = (ftype == 2'b01 && fcode == 2'b00);
        d_memwr   = (ftype == 2'b01 && fcode == 2'b01);
        d_branch  = (ftype == 2'b10);
        d_cachewr = (ftype == 2'b11 && fcode == 2'b10);
        // MOV and all type-11 ops take a constant zero as operand A
        a_zero    = (ftype == 2'b00 && fcode == 2'b10) || (ftype == 2'b11);
        a_used    = !a_zero;
        // Non-writing, non-memory ops (CMP and friends) read RD as operand A
        a_addr    = (d_wb || d_memrd || d_memwr) ? f_rs : f_rd;
        b_used    = !(selimm || d_cachewr);
        if (d_cachewr) begin
            imm_val = BUS'(bus.in_instr[23:20]);
        end else if (ftype == 2'b00) begin
            imm_val = BUS'(bus.in_instr[19:1]);
        end else begin
            imm_val = BUS'(bus.in_instr[27:0]);
        end
    end

    assign bus.rf_ra_addr = a_addr;
    assign bus.rf_rb_addr = f_rx;

    // RAW and counter-saturation hazard detection against the scoreboard
    always_comb begin
        cnt_a = cnt[a_addr];
        cnt_b = cnt[f_rx];
        byp_a = 1'b0;
        byp_b = 1'b0;
`ifdef DECODE_WB_BYPASS_EN
        byp_a = bus.wb_we && (bus.wb_rd == a_addr);
        byp_b = bus.wb_we && (bus.wb_rd == f_rx);
        if (byp_a && cnt_a != '0) cnt_a = cnt_a - 1'b1;
        if (byp_b && cnt_b != '0) cnt_b = cnt_b - 1'b1;
`endif
        // The held bundle has not been counted yet but will write its RD
        held_a  = bus.out_valid && bus.out_wb && (bus.out_rd == a_addr);
        held_b  = bus.out_valid && bus.out_wb && (bus.out_rd == f_rx);
        held_rd = bus.out_valid && bus.out_wb && (bus.out_rd == f_rd);
        haz_a   = a_used && (a_addr != NO_REG) && (cnt_a != '0 || held_a);
        haz_b   = b_used && (f_rx != NO_REG) && (cnt_b != '0 || held_b);
        // A writer may not push its counter past all-ones; a held writer to the
        // same RD already claims one slot, so one below the maximum is also full.
        rd_full = d_wb && (f_rd != NO_REG) &&
                  (cnt[f_rd] == CNT_MAX || (cnt[f_rd] == CNT_NEAR && held_rd));
        stall   = bus.in_valid && (haz_a || haz_b || rd_full);
    end

    assign bus.in_ready = rst_n && (bus.flush || (!stall && (!bus.out_valid || bus.out_ready)));
    assign in_fire      = bus.in_valid && bus.in_ready && !bus.flush;
    assign out_fire     = bus.out_valid && bus.out_ready && !bus.flush;

    // Operand values, with optional same-cycle writeback forwarding
    always_comb begin
        opa_val = '0;
        if (!a_zero) opa_val = byp_a ? bus.wb_data : bus.rf_ra_data;
        opb_val = imm_val;
        if (b_used) opb_val = byp_b ? bus.wb_data : bus.rf_rb_data;
    end

    // Scoreboard next state: +1 on issue of a writer, -1 on writeback, never below zero
    always_comb begin
        inc_vec = (out_fire && bus.out_wb && bus.out_rd != NO_REG) ?
                  (NUM_REGS'(1) << bus.out_rd) : '0;
        dec_vec = (bus.wb_we && bus.wb_rd != NO_REG) ? (NUM_REGS'(1) << bus.wb_rd) : '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_nxt[i] = cnt[i];
            busy[i]    = (cnt[i] != '0);
            if (inc_vec[i] && !(dec_vec[i] && cnt[i] != '0)) begin
                cnt_nxt[i] = cnt[i] + 1'b1;
            end else if (dec_vec[i] && cnt[i] != '0 && !inc_vec[i]) begin
                cnt_nxt[i] = cnt[i] - 1'b1;
            end
        end
    end

    assign bus.busy_mask = busy;

    // Scoreboard counters; flush does not clear them since issued writers still retire
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: this small array is reset explicitly because busy_mask must read zero during reset.
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) cnt[i] <= cnt_nxt[i];
        end
    end

    // Output bundle register: flush beats capture, capture beats drain
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (!rst_n) begin
            bus.out_valid   <= 1'b0;
            bus.out_funtype <= '0;
            bus.out_funcode <= '0;
            bus.out_rd      <= '0;
            bus.out_opa     <= '0;
            bus.out_opb     <= '0;
            bus.out_pc      <= '0;
            bus.out_wb      <= 1'b0;
            bus.out_memrd   <= 1'b0;
            bus.out_memwr   <= 1'b0;
            bus.out_branch  <= 1'b0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
        end else if (in_fire) begin
            bus.out_valid   <= 1'b1;
            bus.out_funtype <= ftype;
            bus.out_funcode <= fcode;
            bus.out_rd      <= f_rd;
            bus.out_opa     <= opa_val;
            bus.out_opb     <= opb_val;
            bus.out_pc      <= bus.in_pc;
            bus.out_wb      <= d_wb;
            bus.out_memrd   <= d_memrd;
            bus.out_memwr   <= d_memwr;
            bus.out_branch  <= d_branch;
        end else if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
        end
    end
endmodule
